// File: rtl/sa_feed_ctrl_if.sv
// Load/start handshake and SA-facing outputs of the systolic-array feed sequencer.
interface sa_feed_ctrl_if #(
   parameter int DATA_W = 8
);
   logic              load_valid;
   logic              load_ready;
   logic [DATA_W-1:0] load_data;
   logic              start;
   logic              busy;
   logic              sa_clear;
   logic              feed_active;
   logic [DATA_W-1:0] subject_out_1;
   logic [DATA_W-1:0] subject_out_2;
   logic [DATA_W-1:0] subject_out_3;
   logic              done;

   modport master (
      output load_valid, load_data, start,
      input  load_ready, busy, sa_clear, feed_active,
             subject_out_1, subject_out_2, subject_out_3, done
   );

   modport slave (
      input  load_valid, load_data, start,
      output load_ready, busy, sa_clear, feed_active,
             subject_out_1, subject_out_2, subject_out_3, done
   );
endinterface

// File: rtl/sa_feed_ctrl.sv
// Buffers a 3-lane subject matrix, then clears the SA and streams it with a per-lane diagonal skew.
module sa_feed_ctrl #(
   parameter int DATA_W       = 8,
   parameter int COLS         = 8,
   parameter int DRAIN_CYCLES = 4
) (
   input  logic          clk,
   input  logic          reset,
   sa_feed_ctrl_if.slave bus
);
   localparam int TOT = 3 * COLS;
   localparam int WW  = $clog2(TOT + 1);
   localparam int AW  = $clog2(TOT);
   localparam int TW  = $clog2(COLS + 3);
   localparam int DW  = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;

   typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_t;

   state_t                      state, state_n;
   logic [WW-1:0]               wr_cnt;
   logic [TW-1:0]               t;
   logic [DW-1:0]               d_cnt;
   logic [DATA_W-1:0]           mem [TOT];
   logic                        full, accept;
   logic [2:0][DATA_W-1:0]      feed_val, subj;
   logic                        clr_q, fa_q, done_q;
   int                          col;

   assign full           = (wr_cnt == WW'(TOT));
   assign bus.load_ready = (state == IDLE) && !full;
   assign accept         = bus.load_valid && bus.load_ready;
   assign bus.busy       = (state != IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:  if (bus.start && full) state_n = CLEAR;
         CLEAR: state_n = FEED;
         FEED:  if (t == TW'(COLS + 1)) state_n = (DRAIN_CYCLES == 0) ? DONE : DRAIN;
         DRAIN: if (d_cnt == DW'(DRAIN_CYCLES - 1)) state_n = DONE;
         DONE:  state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Counters saturate at their terminal value; leaving the state rearms them.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_cnt <= '0;
         t      <= '0;
         d_cnt  <= '0;
      end else begin
         if (state == DONE)  wr_cnt <= '0;
         else if (accept)    wr_cnt <= wr_cnt + 1'b1;
         if (state != FEED)               t <= '0;
         else if (t != TW'(COLS + 1))     t <= t + 1'b1;
         if (state != DRAIN)                       d_cnt <= '0;
         else if (d_cnt != DW'(DRAIN_CYCLES - 1))  d_cnt <= d_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) mem[AW'(wr_cnt)] <= bus.load_data;
   end

   // Lane k (0-based) lags by k cycles; out-of-range columns feed zero.
   always_comb begin
      feed_val = '0;
      col      = 0;
      if (state == FEED) begin
         for (int k = 0; k < 3; k++) begin
            col = int'(t) - k;
            if (col >= 0 && col < COLS) feed_val[k] = mem[AW'(k * COLS + col)];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         clr_q  <= 1'b0;
         fa_q   <= 1'b0;
         done_q <= 1'b0;
         subj   <= '0;
      end else begin
         clr_q  <= (state == CLEAR);
         fa_q   <= (state == FEED);
         done_q <= (state == DONE);
         subj   <= feed_val;
      end
   end

   assign bus.sa_clear      = clr_q;
   assign bus.feed_active   = fa_q;
   assign bus.done          = done_q;
   assign bus.subject_out_1 = subj[0];
   assign bus.subject_out_2 = subj[1];
   assign bus.subject_out_3 = subj[2];
endmodule

// File: tb/tb_sa_feed_ctrl.sv
// Randomized bench for sa_feed_ctrl against a start-relative schedule model of the feed pass.
module tb_sa_feed_ctrl;
   localparam int COLS     = 8;
   localparam int DRAIN    = 4;
   localparam int TOT      = 3 * COLS;
   localparam int DONE_OFF = COLS + 4 + DRAIN;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   sa_feed_ctrl_if #(.DATA_W(8)) bus();
   sa_feed_ctrl #(.DATA_W(8), .COLS(COLS), .DRAIN_CYCLES(DRAIN)) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   int n_chk = 0, n_pass = 0;

   // model: buffer contents, fill count, and edges since start was accepted (-1 = idle)
   logic [7:0] mbuf [TOT];
   int         mcnt, moff;
   bit         mdone, use_tbl;
   logic [7:0] pat [TOT];
   logic [7:0] ref_pat [TOT] = '{13,9,5,233,64,255,2,123,
                                 64,255,2,123,55,1,3,12,
                                 55,1,3,12,27,12,3,3};
   logic [7:0] tbl1 [10] = '{13,9,5,233,64,255,2,123,0,0};
   logic [7:0] tbl2 [10] = '{0,64,255,2,123,55,1,3,12,0};
   logic [7:0] tbl3 [10] = '{0,0,55,1,3,12,27,12,3,3};
   int         acc_cnt;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
   endtask

   function automatic logic [7:0] exp_lane(input int k);
      int tt, c;
      tt = moff - 2;
      c  = tt - k;
      if (moff >= 2 && moff <= COLS + 3 && c >= 0 && c < COLS) return mbuf[k * COLS + c];
      return 8'd0;
   endfunction

   task automatic check_all();
      chk("load_ready", bus.load_ready, (moff < 0 && mcnt < TOT));
      chk("busy", bus.busy, (moff >= 0));
      chk("sa_clear", bus.sa_clear, (moff == 1));
      chk("feed_active", bus.feed_active, (moff >= 2 && moff <= COLS + 3));
      chk("done", bus.done, mdone);
      chk("subj1", bus.subject_out_1, exp_lane(0));
      chk("subj2", bus.subject_out_2, exp_lane(1));
      chk("subj3", bus.subject_out_3, exp_lane(2));
      if (use_tbl && moff >= 2 && moff <= COLS + 3) begin
         chk("tbl1", bus.subject_out_1, tbl1[moff - 2]);
         chk("tbl2", bus.subject_out_2, tbl2[moff - 2]);
         chk("tbl3", bus.subject_out_3, tbl3[moff - 2]);
      end
   endtask

   task automatic model_reset();
      moff = -1; mcnt = 0; mdone = 0;
   endtask

   // one clock: inputs sampled before the edge, model advanced, outputs checked 1 time unit later
   task automatic tick();
      logic cv, cs, crst, cr;
      logic [7:0] cd;
      bit was_full;
      cv = bus.load_valid; cd = bus.load_data; cs = bus.start; crst = reset; cr = bus.load_ready;
      @(posedge clk);
      if (cv && cr && !crst) acc_cnt++;
      mdone = 0;
      if (crst) model_reset();
      else if (moff < 0) begin
         was_full = (mcnt == TOT);
         if (cv && mcnt < TOT) begin mbuf[mcnt] = cd; mcnt++; end
         if (cs && was_full) moff = 0;
      end else begin
         moff++;
         if (moff == DONE_OFF) begin moff = -1; mcnt = 0; mdone = 1; end
      end
      #1 check_all();
      @(negedge clk);
   endtask

   task automatic load_pat();
      int n = 0;
      while (mcnt < TOT && n < 200) begin
         bus.load_valid = ($urandom % 4) != 0;
         bus.load_data  = pat[mcnt];
         tick();
         n++;
      end
      bus.load_valid = 1'b0;
   endtask

   task automatic pulse_start();
      bus.start = 1'b1; tick(); bus.start = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      bus.load_valid = 1'b0; bus.load_data = '0; bus.start = 1'b0;
      use_tbl = 0;
      model_reset();
      @(negedge clk);
      // reset held two cycles
      tick(); tick();
      reset = 1'b0;
      tick();

      // reference pass
      foreach (pat[i]) pat[i] = ref_pat[i];
      load_pat();
      use_tbl = 1;
      pulse_start();
      repeat (DONE_OFF + 2) tick();
      use_tbl = 0;

      // partial load then start is ignored
      for (int i = 0; i < 10; i++) pat[i] = 8'($urandom);
      for (int i = 0; i < 10; i++) begin
         bus.load_valid = 1'b1; bus.load_data = pat[i]; tick();
      end
      bus.load_valid = 1'b0;
      pulse_start();
      repeat (3) tick();

      // overfill: 30 cycles of valid with incrementing data
      reset = 1'b1; tick(); tick(); reset = 1'b0;
      acc_cnt = 0;
      for (int i = 0; i < 30; i++) begin
         bus.load_valid = 1'b1; bus.load_data = 8'(i); tick();
      end
      bus.load_valid = 1'b0;
      chk("accepted", acc_cnt, TOT);
      chk("ready_full", bus.load_ready, 1'b0);
      pulse_start();
      repeat (DONE_OFF + 1) tick();

      // start mid-feed is ignored
      foreach (pat[i]) pat[i] = 8'($urandom);
      load_pat();
      pulse_start();
      while (moff >= 0 && moff < 5) tick();
      pulse_start();
      repeat (DONE_OFF) tick();

      // async reset at feed cycle 4
      foreach (pat[i]) pat[i] = 8'($urandom);
      load_pat();
      pulse_start();
      while (moff >= 0 && moff < 6) tick();
      #2 reset = 1'b1;
      #1 model_reset();
      check_all();
      tick(); tick();
      reset = 1'b0;
      repeat (DONE_OFF) tick();
      chk("no_done_count", mcnt, 0);

      // back-to-back: start in the done cycle is ignored, then reload and rerun
      foreach (pat[i]) pat[i] = ref_pat[i];
      load_pat();
      use_tbl = 1;
      pulse_start();
      while (moff >= 0) tick();
      pulse_start();
      load_pat();
      pulse_start();
      repeat (DONE_OFF + 2) tick();
      use_tbl = 0;

      // random traffic
      for (int i = 0; i < 600; i++) begin
         bus.load_valid = 1'($urandom % 2);
         bus.load_data  = 8'($urandom);
         bus.start      = (($urandom % 6) == 0);
         tick();
      end
      bus.load_valid = 1'b0; bus.start = 1'b0;
      repeat (DONE_OFF + 2) tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
